// File: rtl/nibble_add_exerciser.sv
// Self-test initiator for the registered nibble adder: sweeps all 256 {A,B} operand bytes and checks each registered result.
// Optional macro NIBBLE_EXERCISER_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module nibble_add_exerciser #(
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned SUM_WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] op_out,
  input  logic [7:0] res_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [7:0] fail_op,
  output logic [7:0] fail_res
);

  localparam int unsigned HOLD_W = 3;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [BYTE_W-1:0]   op_q, op_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [BYTE_W-1:0]   err_q, err_d;
  logic [BYTE_W-1:0]   fop_q, fop_d;
  logic [BYTE_W-1:0]   fres_q, fres_d;

  logic [4:0]          sum_c;
  logic [BYTE_W-1:0]   exp_c;
  logic                mismatch_c;
  logic                stop_c;

  // Golden sum of the vector currently on op_out, truncated to SUM_WIDTH bits
  assign sum_c = {1'b0, op_q[7:4]} + {1'b0, op_q[3:0]};

  generate
    if (SUM_WIDTH >= 5) begin : g_carry
      assign exp_c = {3'b000, sum_c};
    end else begin : g_trunc
      assign exp_c = {4'b0000, sum_c[3:0]};
    end
  endgenerate

  assign mismatch_c = (res_in != exp_c);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    op_d    = op_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fop_d   = fop_q;
    fres_d  = fres_q;
    stop_c  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        op_d = '0;
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fop_d   = '0;
          fres_d  = '0;
          hold_d  = '0;
        end
      end
      RUN: begin
        if (hold_q != HOLD_W'(LATENCY)) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          hold_d = '0;
          if (mismatch_c) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (err_q == 8'h00) begin
              fop_d  = op_q;
              fres_d = res_in;
            end
`ifdef NIBBLE_EXERCISER_STOP_ON_FAIL_EN
            stop_c = 1'b1;
`endif
          end
          // pass is taken from err_d so a failure on the final vector counts
          if ((op_q == 8'hFF) || stop_c) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 8'h00);
            op_d    = '0;
          end else begin
            op_d = op_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        op_d    = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fop_q   <= '0;
      fres_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fop_q   <= fop_d;
      fres_q  <= fres_d;
    end
  end

  assign op_out   = op_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_op  = fop_q;
  assign fail_res = fres_q;

endmodule

// File: tb/tb_nibble_add_exerciser.sv
// Directed bench for nibble_add_exerciser with a behavioural registered adder (ideal, bit-3 stuck-at-0, forced 0xFF).
module tb_nibble_add_exerciser;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] op_out;
  logic [7:0] res_in;
  logic       busy, done, pass;
  logic [7:0] err_cnt, fail_op, fail_res;

  int n_tests;
  int n_fail;
  int mode;   // 0 ideal, 1 bit3 stuck at 0, 2 forced 0xFF

  nibble_add_exerciser #(.LATENCY(1), .SUM_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_out(op_out), .res_in(res_in),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_op(fail_op), .fail_res(fail_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle registered adder model, sum mod 16
  always @(posedge clk) begin
    logic [3:0] s;
    s = op_out[7:4] + op_out[3:0];
    case (mode)
      1:       res_in <= {4'h0, 1'b0, s[2:0]};
      2:       res_in <= 8'hFF;
      default: res_in <= {4'h0, s};
    endcase
  end

  always @(negedge clk) begin
    if (rst_n && busy && done) begin
      n_tests++;
      n_fail++;
      $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both 1", busy, done);
    end
  end

  // Pulse start so it is sampled on the next rising edge (edge S); returns #1 after S
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after S until done; optionally pulses start when the count equals start_at
  task automatic wait_done(input int start_at, output int cycles);
    cycles = 0;
    while (cycles < 2000) begin
      start = (cycles == start_at);
      @(posedge clk);
      #1;
      cycles++;
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    n_tests++;
    if ({op_out, busy, done, pass, err_cnt, fail_op, fail_res} !== 35'd0) begin
      n_fail++;
      $display("FAIL %s: op=%h busy=%b done=%b pass=%b err=%h fop=%h fres=%h required all 0",
               name, op_out, busy, done, pass, err_cnt, fail_op, fail_res);
    end
  endtask

  task automatic check_result(input string name, input int cyc, input int exp_cyc,
                              input logic exp_pass, input logic [7:0] exp_err,
                              input logic [7:0] exp_fop, input logic [7:0] exp_fres);
    n_tests++;
    if (cyc !== exp_cyc || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_timing: done after %0d edges (done=%b busy=%b) required %0d", name, cyc, done, busy, exp_cyc);
    end
    n_tests++;
    if (pass !== exp_pass || err_cnt !== exp_err) begin
      n_fail++;
      $display("FAIL %s_result: pass=%b err=%0d required pass=%b err=%0d", name, pass, err_cnt, exp_pass, exp_err);
    end
    n_tests++;
    if (fail_op !== exp_fop || fail_res !== exp_fres || op_out !== 8'h00) begin
      n_fail++;
      $display("FAIL %s_capture: fop=%h fres=%h op=%h required fop=%h fres=%h op=00",
               name, fail_op, fail_res, op_out, exp_fop, exp_fres);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    check_all_zero("reset_asserted");
    #20;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("idle_no_start");
  endtask

  task automatic test_ideal_sweep();
    int cyc;
    logic [7:0] exp_seq [5];
    exp_seq = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h02};
    mode = 0;
    pulse_start();
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0 || op_out !== 8'h00) begin
      n_fail++;
      $display("FAIL ideal_start: busy=%b done=%b op=%h required busy=1 done=0 op=00", busy, done, op_out);
    end
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      n_tests++;
      if (op_out !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL ideal_op_seq[%0d]: op=%h required %h", i + 1, op_out, exp_seq[i]);
      end
    end
    begin
      int rest;
      wait_done(-1, rest);
      cyc += rest;
    end
    check_result("ideal", cyc, 512, 1'b1, 8'd0, 8'h00, 8'h00);
  endtask

  task automatic test_stuck_bit3();
    int cyc;
    mode = 1;
    pulse_start();
    wait_done(-1, cyc);
`ifdef NIBBLE_EXERCISER_STOP_ON_FAIL_EN
    check_result("stuck3", cyc, 18, 1'b0, 8'd1, 8'h08, 8'h00);
`else
    check_result("stuck3", cyc, 512, 1'b0, 8'd128, 8'h08, 8'h00);
`endif
  endtask

  task automatic test_restart_from_done();
    int cyc;
    mode = 0;
    pulse_start();
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 8'd0 || fail_op !== 8'h00) begin
      n_fail++;
      $display("FAIL done_restart_clear: busy=%b done=%b pass=%b err=%0d fop=%h required 1 0 0 0 00",
               busy, done, pass, err_cnt, fail_op);
    end
    wait_done(-1, cyc);
    check_result("restart", cyc, 512, 1'b1, 8'd0, 8'h00, 8'h00);
  endtask

  task automatic test_saturate();
    int cyc;
    mode = 2;
    pulse_start();
    wait_done(-1, cyc);
`ifdef NIBBLE_EXERCISER_STOP_ON_FAIL_EN
    check_result("force_ff", cyc, 2, 1'b0, 8'd1, 8'h00, 8'hFF);
`else
    check_result("force_ff", cyc, 512, 1'b0, 8'd255, 8'h00, 8'hFF);
`endif
  endtask

  task automatic test_start_in_run();
    int cyc;
    mode = 0;
    pulse_start();
    wait_done(99, cyc);
    check_result("start_in_run", cyc, 512, 1'b1, 8'd0, 8'h00, 8'h00);
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    mode = 2;
    pulse_start();
    repeat (199) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_sweep");
    #10;
    rst_n = 1'b1;
    mode = 0;
    pulse_start();
    wait_done(-1, cyc);
    check_result("after_reset", cyc, 512, 1'b1, 8'd0, 8'h00, 8'h00);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    mode    = 0;
    start   = 1'b0;
    rst_n   = 1'b0;
    test_reset();
    test_ideal_sweep();
    test_stuck_bit3();
    test_restart_from_done();
    test_saturate();
    test_start_in_run();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_add_exerciser.md
Name: nibble_add_exerciser

Overview:
- On-chip initiator for the registered nibble adder. It drives packed operand bytes into the adder: operand A in bits [7:4], operand B in bits [3:0].
- It samples the adder's registered result byte, compares it against a golden sum, and reports pass/fail, an error count, and the first failing vector.
- Sits beside the adder in the tt_um top: op_out feeds the adder's ui_in, and the adder's uo_out feeds res_in. Used for post-silicon self-test.

Parameters:
- LATENCY, 1, clock edges from operand change to adder output register update; legal range 1..4.
- SUM_WIDTH, 4, number of valid result bits; 4 means the sum is truncated mod 16, 5 means the carry appears in bit 4. Legal range 4..5.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to run a full sweep
- op_out  output  8  operand byte to the adder, {A,B}
- res_in  input  8  adder result byte
- busy  output  1  high while a sweep is in progress
- done  output  1  high from sweep end until the next accepted start
- pass  output  1  high with done when err_cnt==0
- err_cnt  output  8  count of mismatching vectors, saturating at 255
- fail_op  output  8  op_out value of the first mismatch
- fail_res  output  8  res_in value captured at the first mismatch

Behaviour:
- Reset: clk and rst_n only; rst_n low clears all state asynchronously, regardless of state.
  - All outputs go to 0; state goes to IDLE.
  - Reset mid-sweep aborts the sweep. No partial results are retained.
- States: IDLE, RUN, DONE.
- IDLE:
  - op_out = 0x00.
  - start=1 at edge S moves to RUN. At the same edge: busy=1; done, pass, err_cnt, fail_op and fail_res cleared; vector index k=0; op_out=0x00.
- RUN, vector sequencing:
  - Vectors are k = 0..255 in increasing order, with op_out = k.
  - Each vector is held for LATENCY+1 cycles.
  - res_in is sampled at edge S+(k+1)*(LATENCY+1). op_out advances to k+1 on that same edge.
- Expected result: zero-extend to 8 bits of ((A+B) mod 2^SUM_WIDTH). Any difference in any of the 8 bits is a mismatch, including the upper bits, which must be 0.
- On a mismatch:
  - err_cnt increments, saturating at 255.
  - If it is the first mismatch of the sweep, fail_op=k and fail_res=res_in are captured. Later mismatches never overwrite them.
- After the sample of k=255, at edge S+256*(LATENCY+1):
  - Move to DONE.
  - busy=0, done=1, pass=(final err_cnt==0). pass accounts for a mismatch on the last vector itself.
  - op_out returns to 0x00.
- DONE:
  - Results hold.
  - start=1 starts a new sweep exactly as from IDLE.
- start while in RUN is ignored; it never restarts or extends the sweep.
- start held high continuously: a new sweep begins on the edge after each DONE entry.
- done and busy are never high together.
- err_cnt wrap-around is forbidden; it stays at 255.

Optional Feature:
- Macro: NIBBLE_EXERCISER_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the sweep at its sample edge.
  - Move to DONE with err_cnt=1, pass=0, fail_op and fail_res captured.
  - op_out returns to 0x00.
- Undefined: the full 256-vector sweep always runs, as described above.

Test Plan:
- Reset: rst_n=0 -> op_out, busy, done, pass, err_cnt, fail_op and fail_res all 0. Then rst_n=1, no start -> state stays IDLE, op_out=0x00.
- Ideal adder model (LATENCY=1, SUM_WIDTH=4), start pulse at edge S:
  - busy=1 from S.
  - done=1 and pass=1 at S+512, with err_cnt=0.
  - op_out sequence is 0x00,0x00,0x01,0x01,...
- Adder model with res bit 3 stuck at 0 -> done at S+512, err_cnt=128, fail_op=0x08, fail_res=0x00, pass=0. With NIBBLE_EXERCISER_STOP_ON_FAIL_EN defined -> done at S+18, err_cnt=1.
- res_in forced to 0xFF -> err_cnt saturates at 255 (not 0), fail_op=0x00, fail_res=0xFF, pass=0.
- start pulsed at S+100 during RUN -> ignored; done still at S+512. start pulsed in DONE -> err_cnt, done and pass cleared and a new sweep runs.
- rst_n asserted at S+200 mid-sweep -> all outputs 0 immediately, without waiting for a clock edge. A following start runs a clean full sweep with pass=1.
